// File: rtl/ifmap_stream_framer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ifmap_stream_framer_pkg
// Description : Shared types and constants for the ifmap stream framer.
//               Contains the FSM state encoding, the row tag constants, and
//               a helper that builds a tag from first/last flags.
// Macro       : FRAMER_FLUSH_EN adds the FLUSH state to the encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package ifmap_stream_framer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROW   = 2'd1,
        ST_DONE  = 2'd2
`ifdef FRAMER_FLUSH_EN
        ,
        ST_FLUSH = 2'd3
`endif
    } state_t;

    localparam logic [1:0] TAG_START  = 2'b10;
    localparam logic [1:0] TAG_END    = 2'b01;
    localparam logic [1:0] TAG_SINGLE = 2'b11;
    localparam logic [1:0] TAG_MID    = 2'b00;

    // A one-word row is both first and last, which yields TAG_SINGLE.
    function automatic logic [1:0] make_tag(input logic first, input logic last);
        logic [1:0] tag;
        if (first && last) begin
            tag = TAG_SINGLE;
        end else if (first) begin
            tag = TAG_START;
        end else if (last) begin
            tag = TAG_END;
        end else begin
            tag = TAG_MID;
        end
        return tag;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ifmap_stream_framer_row_counter.sv
`default_nettype none
// ============================================================================
// Module      : framer_row_counter
// Description : Per-channel word-in-row counter. Counts accepted words and
//               wraps to zero after row_len-1. Keeps its value while the
//               framer is serving other channels.
// Ports       : clk, reset      - clock, synchronous active-high reset
//               clear           - restart at word 0 (new job)
//               advance         - one word of this channel accepted
//               row_len         - effective row length (never zero)
//               is_first/is_last- current position is row word 0 / row_len-1
// Revision    : 1.0 - initial release
// ============================================================================
module framer_row_counter
    import ifmap_stream_framer_pkg::*;
#(
    parameter int LEN_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 advance,
    input  logic [LEN_WIDTH-1:0] row_len,
    output logic                 is_first,
    output logic                 is_last
);

    localparam logic [LEN_WIDTH-1:0] c_one = LEN_WIDTH'(1);

    logic [LEN_WIDTH-1:0] count_q;
    logic [LEN_WIDTH-1:0] count_d;

    assign is_first = (count_q == '0);
    assign is_last  = (count_q == (row_len - c_one));

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (advance) begin
            count_d = is_last ? '0 : (count_q + c_one);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ifmap_stream_framer.sv
`default_nettype none
// ============================================================================
// Module      : ifmap_stream_framer
// Description : Merges CHANNELS ifmap sample streams into one tagged output
//               stream. Each output word is {start_tag,end_tag,sample}; rows
//               are row_len words long. Channels are served either one whole
//               stream at a time or one row at a time (interleaved).
// Ports       : clk, reset                    - clock, sync active-high reset
//               start, row_len, flush_len,
//               interleaved                   - job control (latched at start)
//               in_valid/in_data/in_last/
//               in_ready                      - per-channel input streams
//               out_data/out_chan/out_wen/
//               out_ready                     - tagged output stream
//               busy, done, error             - status (error is sticky)
// Macro       : FRAMER_FLUSH_EN - after all data, emit flush_len zero words
//               per channel before finishing.
// Revision    : 1.0 - initial release
// ============================================================================
module ifmap_stream_framer
    import ifmap_stream_framer_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int CHANNELS   = 2,
    parameter int LEN_WIDTH  = 5
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    start,
    input  logic [LEN_WIDTH-1:0]                    row_len,
    input  logic [LEN_WIDTH-1:0]                    flush_len,
    input  logic                                    interleaved,
    input  logic [CHANNELS-1:0]                     in_valid,
    input  logic [CHANNELS*DATA_WIDTH-1:0]          in_data,
    input  logic [CHANNELS-1:0]                     in_last,
    output logic [CHANNELS-1:0]                     in_ready,
    output logic [DATA_WIDTH+1:0]                   out_data,
    output logic [((CHANNELS>1)?$clog2(CHANNELS):1)-1:0] out_chan,
    output logic                                    out_wen,
    input  logic                                    out_ready,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    error
);

    localparam int                   c_chan_w = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [LEN_WIDTH-1:0] c_len_one = LEN_WIDTH'(1);

    state_t                  state_q, state_d;
    logic [c_chan_w-1:0]     cur_chan_q, cur_chan_d;
    logic [CHANNELS-1:0]     fin_q, fin_d;
    logic [LEN_WIDTH-1:0]    row_len_q, row_len_d;
    logic                    interleaved_q, interleaved_d;
    logic                    error_q, error_d;
    logic [DATA_WIDTH+1:0]   out_data_q, out_data_d;
    logic [c_chan_w-1:0]     out_chan_q, out_chan_d;
    logic                    out_wen_q, out_wen_d;

    logic                    slot_free;
    logic                    accept;
    logic                    cnt_clear;
    logic [CHANNELS-1:0]     cnt_adv;
    logic [CHANNELS-1:0]     cnt_first;
    logic [CHANNELS-1:0]     cnt_last;
    logic                    cur_first;
    logic                    cur_last;
    logic                    cur_in_last;
    logic                    trunc;
    logic [DATA_WIDTH-1:0]   cur_data;

`ifdef FRAMER_FLUSH_EN
    logic [LEN_WIDTH-1:0]    flush_len_q, flush_len_d;
    logic [c_chan_w-1:0]     fl_chan_q, fl_chan_d;
    logic [LEN_WIDTH-1:0]    fl_cnt_q, fl_cnt_d;
    logic                    fl_emitted_q, fl_emitted_d;
    logic                    fl_last;
`else
    logic                    unused_flush_len;
    assign unused_flush_len = ^flush_len;
`endif

    // Round-robin search starting after cur; falls back to cur itself when
    // it is the only channel left unfinished.
    function automatic logic [c_chan_w-1:0] next_unfinished(
        input logic [CHANNELS-1:0] fin,
        input logic [c_chan_w-1:0] cur
    );
        logic [c_chan_w-1:0] pick;
        int                  idx;
        pick = cur;
        for (int k = CHANNELS; k >= 1; k--) begin
            idx = int'(cur) + k;
            if (idx >= CHANNELS) begin
                idx = idx - CHANNELS;
            end
            if (!fin[idx]) begin
                pick = c_chan_w'(idx);
            end
        end
        return pick;
    endfunction

    // The output register can take a new word when empty or draining now.
    assign slot_free = !out_wen_q || out_ready;

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            in_ready[c] = (state_q == ST_ROW) && (cur_chan_q == c_chan_w'(c)) &&
                          !fin_q[c] && slot_free;
            cnt_adv[c]  = in_ready[c] && in_valid[c];
        end
    end

    assign accept      = |cnt_adv;
    assign cur_first   = cnt_first[cur_chan_q];
    assign cur_last    = cnt_last[cur_chan_q];
    assign cur_in_last = in_last[cur_chan_q];
    assign cur_data    = in_data[cur_chan_q*DATA_WIDTH +: DATA_WIDTH];
    // Stream ended before the row did: close the row early and flag it.
    assign trunc       = cur_in_last && !cur_last;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        framer_row_counter #(
            .LEN_WIDTH (LEN_WIDTH)
        ) u_row_counter (
            .clk      (clk),
            .reset    (reset),
            .clear    (cnt_clear),
            .advance  (cnt_adv[g]),
            .row_len  (row_len_q),
            .is_first (cnt_first[g]),
            .is_last  (cnt_last[g])
        );
    end

`ifdef FRAMER_FLUSH_EN
    assign fl_last = (fl_cnt_q == (flush_len_q - c_len_one));
`endif

    always_comb begin
        state_d       = state_q;
        cur_chan_d    = cur_chan_q;
        fin_d         = fin_q;
        row_len_d     = row_len_q;
        interleaved_d = interleaved_q;
        error_d       = error_q;
        out_data_d    = out_data_q;
        out_chan_d    = out_chan_q;
        out_wen_d     = out_wen_q && !out_ready;
        cnt_clear     = 1'b0;
`ifdef FRAMER_FLUSH_EN
        flush_len_d   = flush_len_q;
        fl_chan_d     = fl_chan_q;
        fl_cnt_d      = fl_cnt_q;
        fl_emitted_d  = fl_emitted_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d       = ST_ROW;
                    cur_chan_d    = '0;
                    fin_d         = '0;
                    cnt_clear     = 1'b1;
                    row_len_d     = (row_len == '0) ? c_len_one : row_len;
                    interleaved_d = interleaved;
`ifdef FRAMER_FLUSH_EN
                    flush_len_d   = (flush_len == '0) ? c_len_one : flush_len;
                    fl_chan_d     = '0;
                    fl_cnt_d      = '0;
                    fl_emitted_d  = 1'b0;
`endif
                end
            end
            ST_ROW: begin
                if (accept) begin
                    out_wen_d  = 1'b1;
                    out_chan_d = cur_chan_q;
                    out_data_d = {make_tag(cur_first, cur_last || trunc), cur_data};
                    if (trunc) begin
                        error_d = 1'b1;
                    end
                    if (cur_in_last) begin
                        fin_d[cur_chan_q] = 1'b1;
                    end
                    if (cur_in_last || (interleaved_q && cur_last)) begin
                        cur_chan_d = next_unfinished(fin_d, cur_chan_q);
                    end
                end else if ((&fin_q) && slot_free) begin
                    // Leave only once the final data word is leaving the
                    // output register, so done follows the last transfer.
`ifdef FRAMER_FLUSH_EN
                    state_d = ST_FLUSH;
`else
                    state_d = ST_DONE;
`endif
                end
            end
`ifdef FRAMER_FLUSH_EN
            ST_FLUSH: begin
                if (!fl_emitted_q) begin
                    if (slot_free) begin
                        out_wen_d  = 1'b1;
                        out_chan_d = fl_chan_q;
                        out_data_d = {make_tag(fl_cnt_q == '0, fl_last),
                                      {DATA_WIDTH{1'b0}}};
                        if (fl_last) begin
                            fl_cnt_d = '0;
                            if (fl_chan_q == c_chan_w'(CHANNELS - 1)) begin
                                fl_emitted_d = 1'b1;
                            end else begin
                                fl_chan_d = fl_chan_q + 1'b1;
                            end
                        end else begin
                            fl_cnt_d = fl_cnt_q + c_len_one;
                        end
                    end
                end else if (slot_free) begin
                    state_d = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cur_chan_q    <= '0;
            fin_q         <= '0;
            row_len_q     <= c_len_one;
            interleaved_q <= 1'b0;
            error_q       <= 1'b0;
            out_data_q    <= '0;
            out_chan_q    <= '0;
            out_wen_q     <= 1'b0;
`ifdef FRAMER_FLUSH_EN
            flush_len_q   <= c_len_one;
            fl_chan_q     <= '0;
            fl_cnt_q      <= '0;
            fl_emitted_q  <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cur_chan_q    <= cur_chan_d;
            fin_q         <= fin_d;
            row_len_q     <= row_len_d;
            interleaved_q <= interleaved_d;
            error_q       <= error_d;
            out_data_q    <= out_data_d;
            out_chan_q    <= out_chan_d;
            out_wen_q     <= out_wen_d;
`ifdef FRAMER_FLUSH_EN
            flush_len_q   <= flush_len_d;
            fl_chan_q     <= fl_chan_d;
            fl_cnt_q      <= fl_cnt_d;
            fl_emitted_q  <= fl_emitted_d;
`endif
        end
    end

    assign out_data = out_data_q;
    assign out_chan = out_chan_q;
    assign out_wen  = out_wen_q;
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign error    = error_q;

endmodule
`default_nettype wire

// File: tb/tb_ifmap_stream_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifmap_stream_framer
// Description : Self-checking bench for ifmap_stream_framer (CHANNELS=2).
//               Random streams are generated per channel; the expected output
//               sequence is computed by walking the streams with the framing
//               rules (row positions, round-robin, truncation, flush).
// Macro       : FRAMER_FLUSH_EN - expected stream includes the flush words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifmap_stream_framer;

    localparam int DW = 16;
    localparam int CH = 2;
    localparam int LW = 5;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [LW-1:0]     row_len = '0;
    logic [LW-1:0]     flush_len = '0;
    logic              interleaved = 1'b0;
    logic [CH-1:0]     in_valid = '0;
    logic [CH*DW-1:0]  in_data = '0;
    logic [CH-1:0]     in_last = '0;
    logic [CH-1:0]     in_ready;
    logic [DW+1:0]     out_data;
    logic [0:0]        out_chan;
    logic              out_wen;
    logic              out_ready = 1'b0;
    logic              busy;
    logic              done;
    logic              error;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] stream [CH][64];
    int            slen [CH];
    int            sptr [CH];
    logic [DW+2:0] exp_q [$];   // {chan, tag[1:0], sample}
    bit            exp_err;

    always #5 clk = ~clk;

    ifmap_stream_framer #(
        .DATA_WIDTH (DW),
        .CHANNELS   (CH),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .row_len     (row_len),
        .flush_len   (flush_len),
        .interleaved (interleaved),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_chan    (out_chan),
        .out_wen     (out_wen),
        .out_ready   (out_ready),
        .busy        (busy),
        .done        (done),
        .error       (error)
    );

    task automatic make_stream(input int c, input int n);
        slen[c] = n;
        for (int i = 0; i < n; i++) begin
            stream[c][i] = DW'($urandom);
        end
    endtask

    // Walk the streams word by word applying the framing rules.
    function automatic void build_expected(input int l_in, input bit il, input int f_in);
        int  l;
        int  pos [CH];
        int  idx [CH];
        bit  fin [CH];
        int  cur;
        bit  first;
        bit  last;
        bit  rowend;
        bit  found;
        int  n;
        l = (l_in == 0) ? 1 : l_in;
        exp_q.delete();
        exp_err = 1'b0;
        cur = 0;
        for (int c = 0; c < CH; c++) begin
            pos[c] = 0;
            idx[c] = 0;
            fin[c] = 1'b0;
        end
        while (!(fin[0] && fin[1])) begin
            first  = (pos[cur] == 0);
            rowend = (pos[cur] == l - 1);
            last   = (idx[cur] == slen[cur] - 1);
            if (last && !rowend) exp_err = 1'b1;
            exp_q.push_back({1'(cur), first, rowend || last, stream[cur][idx[cur]]});
            idx[cur] = idx[cur] + 1;
            pos[cur] = rowend ? 0 : pos[cur] + 1;
            if (last) fin[cur] = 1'b1;
            if (last || (il && rowend)) begin
                found = 1'b0;
                for (int k = 1; k <= CH; k++) begin
                    n = (cur + k) % CH;
                    if (!found && !fin[n]) begin
                        cur = n;
                        found = 1'b1;
                    end
                end
            end
        end
`ifdef FRAMER_FLUSH_EN
        begin
            int fl;
            fl = (f_in == 0) ? 1 : f_in;
            for (int c = 0; c < CH; c++) begin
                for (int j = 0; j < fl; j++) begin
                    exp_q.push_back({1'(c), (j == 0), (j == fl - 1), {DW{1'b0}}});
                end
            end
        end
`else
        if (f_in < 0) exp_err = 1'b1;   // flush length has no effect in this build
`endif
    endfunction

    task automatic run_job(input int l, input bit il, input int f, input int mode,
                           input int reset_at);
        int  last_xfer;
        bit  hold_v;
        bit  fin_loop;
        logic [DW+2:0] hold_w;
        logic [DW+2:0] got;
        logic [DW+2:0] want;
        for (int c = 0; c < CH; c++) sptr[c] = 0;
        build_expected(l, il, f);
        @(negedge clk);
        reset = 1'b1; start = 1'b0; in_valid = '0; out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        row_len = LW'(l); flush_len = LW'(f); interleaved = il; start = 1'b1;
        last_xfer = -1;
        hold_v = 1'b0;
        hold_w = '0;
        fin_loop = 1'b0;
        for (int cyc = 0; cyc < 3000 && !fin_loop; cyc++) begin
            @(negedge clk);
            if (reset_at > 0 && cyc == reset_at) begin
                start = 1'b0; in_valid = '0; reset = 1'b1;
                @(negedge clk);
                #1;
                checks += 3;
                if (out_wen !== 1'b0) begin
                    failures++; $display("FAIL midjob_reset_wen got=%b want=0", out_wen);
                end
                if (busy !== 1'b0) begin
                    failures++; $display("FAIL midjob_reset_busy got=%b want=0", busy);
                end
                if (in_ready !== '0) begin
                    failures++; $display("FAIL midjob_reset_in_ready got=%b want=0", in_ready);
                end
                reset = 1'b0;
                exp_q.delete();
                return;
            end
            // Job parameters are latched at start; later changes must not matter.
            start       = ($urandom_range(0, 7) == 0);
            row_len     = LW'($urandom);
            flush_len   = LW'($urandom);
            interleaved = 1'($urandom_range(0, 1));
            for (int c = 0; c < CH; c++) begin
                if (sptr[c] < slen[c] && (mode != 1 || $urandom_range(0, 3) != 0)) begin
                    in_valid[c] = 1'b1;
                    in_data[c*DW +: DW] = stream[c][sptr[c]];
                    in_last[c] = (sptr[c] == slen[c] - 1);
                end else begin
                    in_valid[c] = 1'b0;
                    in_data[c*DW +: DW] = DW'($urandom);
                    in_last[c] = 1'($urandom_range(0, 1));
                end
            end
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 2) != 0);
                default: out_ready = !(cyc >= 6 && cyc < 10);
            endcase
            #1;
            if (hold_v) begin
                checks++;
                if ({out_wen, out_chan, out_data} !== {1'b1, hold_w}) begin
                    failures++;
                    $display("FAIL hold_stable got=%b_%h want=1_%h", out_wen,
                             {out_chan, out_data}, hold_w);
                end
            end
            if (out_wen && !out_ready) begin
                checks++;
                if (in_ready !== '0) begin
                    failures++; $display("FAIL stall_in_ready got=%b want=00", in_ready);
                end
            end
            checks++;
            if (done !== (last_xfer >= 0 && cyc == last_xfer + 1)) begin
                failures++;
                $display("FAIL done_pulse cyc=%0d got=%b want=%b", cyc, done,
                         (last_xfer >= 0 && cyc == last_xfer + 1));
            end
            if (last_xfer >= 0 && cyc == last_xfer + 1) begin
                checks++;
                if (busy !== 1'b1) begin
                    failures++; $display("FAIL busy_at_done got=%b want=1", busy);
                end
            end
            if (last_xfer >= 0 && cyc == last_xfer + 2) begin
                checks += 2;
                if (busy !== 1'b0) begin
                    failures++; $display("FAIL busy_after_done got=%b want=0", busy);
                end
                if (error !== exp_err) begin
                    failures++; $display("FAIL error_flag got=%b want=%b", error, exp_err);
                end
                fin_loop = 1'b1;
            end
            if (out_wen && out_ready) begin
                got = {out_chan, out_data};
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL extra_word got=%h want=none", got);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        failures++;
                        $display("FAIL word chan/tag/data got=%h want=%h", got, want);
                    end
                    if (exp_q.size() == 0) last_xfer = cyc;
                end
            end
            for (int c = 0; c < CH; c++) begin
                if (in_valid[c] && in_ready[c]) sptr[c]++;
            end
            hold_v = out_wen && !out_ready;
            hold_w = {out_chan, out_data};
        end
        if (!fin_loop) begin
            checks++;
            failures++;
            $display("FAIL job_timeout got=%0d_words_left want=0", exp_q.size());
        end
        start = 1'b0;
        in_valid = '0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks += 7;
        if (out_wen !== 1'b0) begin failures++; $display("FAIL reset_out_wen got=%b want=0", out_wen); end
        if (out_data !== '0) begin failures++; $display("FAIL reset_out_data got=%h want=0", out_data); end
        if (out_chan !== '0) begin failures++; $display("FAIL reset_out_chan got=%h want=0", out_chan); end
        if (in_ready !== '0) begin failures++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
        if (error !== 1'b0) begin failures++; $display("FAIL reset_error got=%b want=0", error); end
        reset = 1'b0;
    endtask

    // Channel 0: two 5-word rows; channel 1 follows with one row.
    task automatic test_sequential_rows();
        make_stream(0, 10);
        make_stream(1, 5);
        run_job(5, 1'b0, 5, 0, 0);
    endtask

    task automatic test_interleave();
        make_stream(0, 6);
        make_stream(1, 6);
        run_job(3, 1'b1, 2, 0, 0);
    endtask

    task automatic test_backpressure();
        make_stream(0, 8);
        make_stream(1, 4);
        run_job(4, 1'b1, 3, 2, 0);
    endtask

    task automatic test_truncate();
        make_stream(0, 2);
        make_stream(1, 5);
        run_job(5, 1'b0, 1, 0, 0);
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (error !== 1'b1) begin failures++; $display("FAIL error_sticky got=%b want=1", error); end
        reset = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (error !== 1'b0) begin failures++; $display("FAIL error_cleared got=%b want=0", error); end
        reset = 1'b0;
    endtask

    task automatic test_reset_midjob();
        make_stream(0, 10);
        make_stream(1, 5);
        run_job(5, 1'b0, 5, 0, 4);
        run_job(5, 1'b0, 5, 0, 0);
    endtask

    task automatic test_row_len_zero();
        make_stream(0, 3);
        make_stream(1, 2);
        run_job(0, 1'b1, 0, 1, 0);
    endtask

    task automatic test_random();
        for (int j = 0; j < 8; j++) begin
            make_stream(0, $urandom_range(1, 12));
            make_stream(1, $urandom_range(1, 12));
            run_job($urandom_range(0, 5), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3), 1, 0);
        end
    endtask

    initial begin
        test_reset();
        test_sequential_rows();
        test_interleave();
        test_backpressure();
        test_truncate();
        test_reset_midjob();
        test_row_len_zero();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ifmap_stream_framer.md
IFMAP_STREAM_FRAMER -- requirements
Module: ifmap_stream_framer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, raw ifmap sample width.
REQ-002 SHALL have parameter CHANNELS, default 2, number of independent input streams (>=1).
REQ-003 SHALL have parameter LEN_WIDTH, default 5, width of row_len and flush_len.
REQ-004 SHALL have ports: clk  in  1  sole clock; reset is synchronous and active-high.
REQ-005 SHALL have port reset  in  1  synchronous active-high reset.
REQ-006 SHALL have ports: start in 1 (begin job); row_len in LEN_WIDTH (words per row); flush_len in LEN_WIDTH (zero-row length); interleaved in 1 (row-interleave channels).
REQ-007 SHALL have ports: in_valid in CHANNELS; in_data in CHANNELS*DATA_WIDTH; in_last in CHANNELS (final word of a stream); in_ready out CHANNELS.
REQ-008 SHALL have ports: out_data out DATA_WIDTH+2 ({start_tag,end_tag,sample}); out_chan out $clog2(CHANNELS) (min 1); out_wen out 1; out_ready in 1.
REQ-009 SHALL have ports: busy out 1; done out 1 (one-cycle pulse); error out 1 (sticky).

Function
REQ-010 Transfer on output SHALL occur when out_wen && out_ready; out_data/out_chan SHALL stay stable while out_wen=1 and out_ready=0.
REQ-011 Input transfer on channel c SHALL occur when in_valid[c] && in_ready[c]; in_ready[c]=1 only in ROW, c==cur_chan, and (!out_wen || out_ready).
REQ-012 Accepted word SHALL appear on out_data with out_wen=1 on the next cycle (latency 1); back-to-back throughput one word/cycle.
REQ-013 Tag SHALL be 2'b10 on row word 0, 2'b01 on word row_len-1, 2'b11 when row_len==1, else 2'b00.
REQ-014 row_len==0 SHALL be treated as 1; row_len and flush_len SHALL be latched at start.
REQ-015 FSM states IDLE, ROW, FLUSH, DONE; IDLE->ROW on start; start ignored while busy.
REQ-016 interleaved=1: after each completed row, cur_chan SHALL advance round-robin to the next channel not yet finished; interleaved=0: cur_chan SHALL stay until its stream finishes, then advance.
REQ-017 in_last on a row-final word SHALL mark that channel finished; in_last on a non-final word SHALL set error and force that word's end_tag=1 (row truncated) and finish the channel.
REQ-018 When all channels finished, FSM SHALL go to FLUSH (if enabled) else DONE.
REQ-019 DONE SHALL last one cycle with done=1, then IDLE; busy=1 in ROW, FLUSH, DONE.
REQ-020 Per-channel word counter SHALL wrap to 0 after row_len-1, independently per channel, preserved across interleave switches.

Reset
REQ-021 On reset: state IDLE, out_wen=0, out_data=0, out_chan=0, in_ready=0, busy=0, done=0, error=0, all counters and finished flags cleared.
REQ-022 Reset mid-job SHALL abort immediately; any pending output word SHALL be discarded.

Configuration
REQ-023 Macro FRAMER_FLUSH_EN defined: FLUSH SHALL emit, for each channel in index order, flush_len zero-sample words tagged per REQ-013 (flush_len==0 treated as 1), then DONE.
REQ-024 FRAMER_FLUSH_EN undefined: FLUSH state and flush_len logic SHALL be absent; flush_len ignored; all-finished goes straight to DONE.

Structure
REQ-025 Shared package SHALL hold the FSM state typedef and tag constants TAG_START=2'b10, TAG_END=2'b01, TAG_SINGLE=2'b11, TAG_MID=2'b00.
REQ-026 One sub-module, framer_row_counter (per-channel word counter with first/last flags), SHALL be instantiated CHANNELS times.

Verification
REQ-027 CHANNELS=1, row_len=5, 10 words, in_last on word 10, out_ready=1 -> tags 10,00,00,00,01,10,00,00,00,01; done one cycle after the last transfer.
REQ-028 CHANNELS=2, interleaved=1, row_len=3, 6 words per channel -> out_chan sequence 0,0,0,1,1,1,0,0,0,1,1,1.
REQ-029 out_ready held low 4 cycles mid-row -> out_data stable, in_ready=0, no word lost or duplicated.
REQ-030 in_last on word 2 of row_len=5 -> that word tagged 01, error=1 until reset.
REQ-031 FRAMER_FLUSH_EN, flush_len=5, CHANNELS=1 -> after data, five zero words tagged 10,00,00,00,01, then done.
REQ-032 reset asserted mid-row -> next cycle out_wen=0, busy=0; a new start reproduces REQ-027 exactly.
